wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/mips_pkg.sv | 26 ++
 rtl/regfile_2r1w.sv | 58 +++++
 rtl/wb_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared write-back definitions: register-file constants, WB control bit
// positions, the write-back FSM state type and the register write payload.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;

  localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

  // Bit positions inside the 2-bit WB control field.
  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_DISPWRITE = 0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  // Single write-port payload; also drives the same-cycle read bypass.
  typedef struct packed {
    logic                en;
    logic [RADDR_W-1:0]  addr;
    logic [XLEN-1:0]     data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two asynchronous read ports, one synchronous write port, hardwired zero
// register and write-first bypass from the write port to both reads.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  rf_wr_t             wr,
  input  logic [RADDR_W-1:0] ra1,
  input  logic [RADDR_W-1:0] ra2,
  output logic [XLEN-1:0]    rd1,
  output logic [XLEN-1:0]    rd2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_ok_c;

  // Writes to r0 or beyond the implemented depth are dropped.
  assign wr_ok_c = wr.en && (wr.addr != REG_ZERO) && (32'(wr.addr) < NREG);

  // Storage array; cleared asynchronously so reset leaves every register 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok_c) begin
      regs_q[wr.addr] <= wr.data;
    end
  end

  // Read port 1: zero register, then bypass, then stored value.
  always_comb begin
    rd1 = '0;
    if (ra1 == REG_ZERO) begin
      rd1 = '0;
    end else if (wr.en && (wr.addr == ra1)) begin
      rd1 = wr.data;
    end else if (32'(ra1) < NREG) begin
      rd1 = regs_q[ra1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = '0;
    if (ra2 == REG_ZERO) begin
      rd2 = '0;
    end else if (wr.en && (wr.addr == ra2)) begin
      rd2 = wr.data;
    end else if (32'(ra2) < NREG) begin
      rd2 = regs_q[ra2];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register file update, display latch, RUN/HALTED FSM and
// optional performance counters (enabled by defining WB_PERF_CNT_EN; when
// undefined the counter outputs are constant 0 and no counter flops exist).
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NREG  = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [XLEN-1:0]    PC_in,
  input  logic [XLEN-1:0]    IR_in,
  input  logic [XLEN-1:0]    WriteData_in,
  input  logic [XLEN-1:0]    Display_in,
  input  logic [RADDR_W-1:0] WR_in,
  input  logic [1:0]         WB_in,
  input  logic               HALT_in,
  input  logic [RADDR_W-1:0] RA1,
  input  logic [RADDR_W-1:0] RA2,
  output logic [XLEN-1:0]    RD1,
  output logic [XLEN-1:0]    RD2,
  output logic [XLEN-1:0]    Display_out,
  output logic               Halted,
  output logic [CNT_W-1:0]   RetireCnt,
  output logic [CNT_W-1:0]   CycleCnt
);

  wb_state_e       state_q;
  wb_state_e       state_d;
  logic            run_c;
  rf_wr_t          rf_wr_c;
  logic [XLEN-1:0] display_q;

  // Next-state logic: a halt retires in RUN and the machine parks in HALTED.
  always_comb begin
    state_d = state_q;
    run_c   = 1'b0;
    if (state_q == RUN) begin
      run_c = 1'b1;
      if (HALT_in) begin
        state_d = HALTED;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign Halted = (state_q == HALTED);

  // Register write request; gated by RUN so HALTED also kills the bypass.
  always_comb begin
    rf_wr_c      = '0;
    rf_wr_c.en   = run_c && WB_in[WB_REGWRITE];
    rf_wr_c.addr = WR_in;
    rf_wr_c.data = WriteData_in;
  end

  regfile_2r1w #(
    .NREG (NREG)
  ) u_regfile (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr    (rf_wr_c),
    .ra1   (RA1),
    .ra2   (RA2),
    .rd1   (RD1),
    .rd2   (RD2)
  );

  // Display latch, loaded by retiring DisplayWrite instructions.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      display_q <= '0;
    end else if (run_c && WB_in[WB_DISPWRITE]) begin
      display_q <= Display_in;
    end
  end

  assign Display_out = display_q;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] cycle_q;
  logic             pc_unused;

  // Cycle and retire counters; both stop in HALTED and wrap silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else if (run_c) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (IR_in != '0) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  assign RetireCnt = retire_q;
  assign CycleCnt  = cycle_q;
  assign pc_unused = ^PC_in;
`else
  logic in_unused;

  assign RetireCnt = '0;
  assign CycleCnt  = '0;
  assign in_unused = ^{PC_in, IR_in};
`endif

endmodule
